// File: rtl/alu_mdu.sv
// alu_mdu: single-cycle ALU plus iterative shift-add multiplier and restoring divider (divider only when ALU_MDU_DIV_EN is defined)
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow,
  output logic             busy
);
  localparam int SHW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, nstate;
  logic [WIDTH-1:0] hi, lo, opb, nhi, nlo, ar, mr;
  logic [WIDTH:0] sum, dif, msum;
  logic [SHW-1:0] cnt, sh;
  logic [1:0] mop;
  logic accept, is_mdu, ac, av, az, mv;
`ifdef ALU_MDU_DIV_EN
  logic [WIDTH:0] dsh;
  logic [WIDTH-1:0] ddif;
  logic dge;
`endif
  assign busy = state == CALC;
  assign out_valid = state == DONE;
  always_comb begin
    in_ready = state == IDLE || (state == DONE && out_ready);
    accept = in_valid && in_ready;
`ifdef ALU_MDU_DIV_EN
    is_mdu = op[4:2] == 3'b100;
`else
    is_mdu = op[4:1] == 4'b1000;
`endif
    nstate = state;
    if (accept) nstate = is_mdu ? CALC : DONE;
    else if (state == DONE && out_ready) nstate = IDLE;
    else if (state == CALC && cnt == '0) nstate = DONE;
  end
  always_comb begin
    sh = a[SHW-1:0];
    sum = {1'b0, a} + {1'b0, b};
    dif = {1'b0, a} - {1'b0, b};
    ar = '0;
    ac = 1'b0;
    av = 1'b0;
    case (op)
      5'b00000: begin ar = sum[WIDTH-1:0]; ac = sum[WIDTH]; end
      5'b00010: begin ar = sum[WIDTH-1:0]; av = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]); end
      5'b00001: begin ar = dif[WIDTH-1:0]; ac = dif[WIDTH]; end
      5'b00011: begin ar = dif[WIDTH-1:0]; av = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]); end
      5'b00100: ar = a & b;
      5'b00101: ar = a | b;
      5'b00110: ar = a ^ b;
      5'b00111: ar = ~(a | b);
      5'b01000, 5'b01001: ar = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      5'b01010: ar = {{(WIDTH-1){1'b0}}, dif[WIDTH]};
      5'b01011: ar = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      // carry picks the last bit shifted out; a zero amount selects the padding zero
      5'b01100: begin ar = $signed(b) >>> sh; ac = |({b, 1'b0} & ((WIDTH+1)'(1) << sh)); end
      5'b01101: begin ar = b >> sh; ac = |({b, 1'b0} & ((WIDTH+1)'(1) << sh)); end
      5'b01110, 5'b01111: begin ar = b << sh; ac = |({1'b0, b} & ((WIDTH+1)'(1) << (WIDTH - int'(sh)))); end
      default: ar = '0;
    endcase
    az = (op == 5'b01010 || op == 5'b01011) ? a == b : ar == '0;
  end
  always_comb begin
    msum = {1'b0, hi} + ({1'b0, opb} & {(WIDTH+1){lo[0]}});
    {nhi, nlo} = {msum, lo[WIDTH-1:1]};
`ifdef ALU_MDU_DIV_EN
    dsh = {hi, lo[WIDTH-1]};
    dge = dsh >= {1'b0, opb};
    ddif = dsh[WIDTH-1:0] - opb;
    if (mop[1]) begin
      nhi = dge ? ddif : dsh[WIDTH-1:0];
      nlo = {lo[WIDTH-2:0], dge};
    end
`endif
    mr = mop[0] ? nhi : nlo;
    mv = mop[1] && opb == '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      {r, zero, carry, negative, overflow} <= '0;
      hi <= '0;
      lo <= '0;
      opb <= '0;
      mop <= '0;
      cnt <= '0;
    end else begin
      state <= nstate;
      if (accept) begin
        hi <= '0;
        lo <= op[1] ? a : b;
        opb <= op[1] ? b : a;
        mop <= op[1:0];
        cnt <= SHW'(WIDTH - 1);
        if (!is_mdu) {r, zero, carry, negative, overflow} <= {ar, az, ac, ar[WIDTH-1], av};
      end else if (state == CALC) begin
        hi <= nhi;
        lo <= nlo;
        cnt <= cnt - 1'b1;
        if (cnt == '0) {r, zero, carry, negative, overflow} <= {mr, mr == '0, 1'b0, mr[WIDTH-1], mv};
      end
    end
  end
endmodule
